// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: DEPTH-entry byte FIFO that hands bytes to a UART transmitter over its start/busy/done handshake.
// Build option: define FEEDER_STATS_EN to add the saturating bytes_sent_o frame counter.
module uart_tx_feeder #(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned START_TIMEOUT = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             s_data_i,
   input  logic                   s_valid_i,
   output logic                   s_ready_o,
   output logic [7:0]             tx_data_o,
   output logic                   tx_start_o,
   input  logic                   tx_busy_i,
   input  logic                   tx_done_i,
   output logic [$clog2(DEPTH):0] fifo_count_o,
`ifdef FEEDER_STATS_EN
   output logic [15:0]            bytes_sent_o,
`endif
   output logic                   err_timeout_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(START_TIMEOUT);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REQ    = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start_q, tx_start_d;
   logic          err_q, err_d;
   logic          push, pop, empty;

   assign empty     = (count_q == '0);
   assign s_ready_o = (count_q != CW'(DEPTH));
   assign push      = s_valid_i && s_ready_o;

   // Power-of-two depth: pointers wrap by plain overflow.
   assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data_i;
   end

   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      tx_data_d  = tx_data_q;
      tx_start_d = tx_start_q;
      err_d      = 1'b0;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               state_d    = ST_REQ;
               pop        = 1'b1;
               tx_data_d  = mem_q[rd_ptr_q];
               tx_start_d = 1'b1;
               tmo_d      = '0;
            end
         end
         ST_REQ: begin
            tmo_d = tmo_q + 1'b1;
            // busy wins over a coincident timeout
            if (tx_busy_i) begin
               state_d    = ST_ACTIVE;
               tx_start_d = 1'b0;
            end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
               state_d    = ST_IDLE;
               tx_start_d = 1'b0;
               err_d      = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (tx_done_i || !tx_busy_i) state_d = ST_IDLE;
         end
         default: begin
            state_d    = ST_IDLE;
            tx_start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_IDLE;
         tmo_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         err_q      <= err_d;
      end
   end

   assign tx_data_o     = tx_data_q;
   assign tx_start_o    = tx_start_q;
   assign fifo_count_o  = count_q;
   assign err_timeout_o = err_q;

`ifdef FEEDER_STATS_EN
   logic [15:0] bytes_sent_q;
   logic        sent;

   assign sent = (state_q == ST_REQ) && tx_busy_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 bytes_sent_q <= '0;
      else if (sent && (bytes_sent_q != 16'hFFFF)) bytes_sent_q <= bytes_sent_q + 16'd1;
   end

   assign bytes_sent_o = bytes_sent_q;
`endif

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-buffering front end that sits directly upstream of the UART transmitter. It accepts bytes from the packet/parser side over a valid/ready stream and stores them in a DEPTH-entry FIFO. It presents one byte at a time to the transmitter using that block's level-sensitive start and busy/done protocol, so upstream logic never has to pace itself to the baud rate.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- START_TIMEOUT, 8: cycles allowed in REQ for tx_busy to rise; ≥4, covering the transmitter's start synchroniser and state register.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  8  upstream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept; equals !full
- tx_data  out  8  byte presented to transmitter; registered, held stable from REQ entry until return to IDLE
- tx_start  out  1  transmit request; registered, high only in REQ
- tx_busy  in  1  transmitter busy
- tx_done  in  1  transmitter frame-complete pulse
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- err_timeout  out  1  one-cycle pulse: request abandoned, byte dropped
- bytes_sent  out  16  only with FEEDER_STATS_EN; see Configuration

## Operation
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Push when s_valid && s_ready.
  - Pop only on the IDLE→REQ transition.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - When full, s_ready=0, so no push occurs.
  - When empty, no pop occurs.
- FSM states: IDLE, REQ, ACTIVE.
- IDLE:
  - If FIFO is non-empty, go to REQ.
  - On the same edge: tx_data←head, pop, tx_start←1, timeout counter←0.
- REQ:
  - tx_start held at 1; counter increments each cycle.
  - If tx_busy=1, go to ACTIVE and set tx_start←0.
  - Else if counter==START_TIMEOUT−1, go to IDLE, set tx_start←0, pulse err_timeout. The byte is lost.
  - tx_busy takes priority over timeout in the same cycle.
- ACTIVE:
  - Wait for tx_done=1 or tx_busy=0, then go to IDLE.
  - tx_start stays 0 for the whole frame, so the transmitter cannot retrigger.
- tx_done or tx_busy seen in IDLE is ignored.
- Reset mid-operation:
  - All state returns to reset values; FIFO contents are discarded.
  - Pointers and count go to 0; the in-flight byte is abandoned.
- Reset values:
  - s_ready=1, tx_start=0, tx_data=8'h00, fifo_count=0, err_timeout=0, bytes_sent=0.
  - State=IDLE, pointers=0.

## Timing
- Byte accepted at edge E0: fifo_count=1 after E0.
- If the FSM is idle: at E1 it enters REQ, tx_start=1, tx_data valid, fifo_count=0. Accept-to-request latency is 1 cycle.
- The transmitter's synchroniser raises tx_busy about 3 cycles after tx_start. tx_start falls on the edge after tx_busy is sampled high.
- tx_done sampled at edge Ed: IDLE after Ed; next REQ at Ed+1 if the FIFO is non-empty.
- Back-to-back bytes therefore have exactly 1 idle-state cycle between frames.
- s_ready is combinational from registered occupancy; no combinational path from s_valid.
- err_timeout is high for exactly the cycle after the timeout edge, in IDLE.

## Configuration
- FEEDER_STATS_EN defined:
  - bytes_sent port exists.
  - 16-bit counter increments on each REQ→ACTIVE transition and saturates at 16'hFFFF.
  - Reset value is 0; cleared only by rst_n.
- FEEDER_STATS_EN undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Single byte 8'hA5 into idle feeder; model transmitter busy 3 cycles after start, 160 cycles long, then tx_done -> tx_start high 1 cycle after accept, tx_data=8'hA5 through the frame, tx_start low after busy seen, fifo_count 1→0.
- Burst 20 bytes 0x00..0x13 with DEPTH=16 and s_valid held -> s_ready drops when fifo_count=16. All 20 bytes are transmitted in order with exactly one IDLE cycle between frames. Pointers wrap correctly.
- Push on the same cycle as a pop, with fifo_count=5 -> fifo_count stays 5; the pushed byte is sent last.
- tx_busy tied 0, byte 8'h3C -> tx_start high exactly START_TIMEOUT cycles, err_timeout pulses once, FSM returns to IDLE, next queued byte is requested.
- rst_n asserted mid-frame with 4 bytes queued -> tx_start=0, fifo_count=0, s_ready=1 immediately. After release, no request until new data arrives.
- FEEDER_STATS_EN defined, 3 bytes sent plus 1 timeout -> bytes_sent=3. With the counter preloaded near saturation in the bench, it holds at 16'hFFFF.
